// File: rtl/pbus_arb_conn_pkg.sv
// Shared bus constants, arbiter state encoding and the address-span mask helper
// used by the peripheral-bus connector and its address decoder.
package pbus_arb_conn_pkg;

    localparam int XLEN        = 32;
    localparam int BUS_WIDTH   = 32;
    localparam int BUS_ACC_CNT = 4;
    localparam int ACC_W       = $clog2(BUS_ACC_CNT);
    localparam int TIMER_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } arb_state_e;

    // Mask covering the low 'span' offset bits of an address.
    function automatic logic [XLEN-1:0] span_mask(input logic [7:0] span);
        if (int'(span) >= XLEN) return '1;
        return (XLEN'(1) << span) - XLEN'(1);
    endfunction

endpackage

// File: rtl/pbus_addr_dec.sv
// Address decoder: matches m_addr against each slave window and reports the
// lowest-index matching slave.
module pbus_addr_dec
    import pbus_arb_conn_pkg::*;
#(
    parameter int                          SLAVE_CNT  = 5,
    parameter logic [XLEN*SLAVE_CNT-1:0]   SLAVE_BASE = {32'hf0000000, 32'hb0000000, 32'ha0000000,
                                                         32'h90000000, 32'h80000000},
    parameter logic [8*SLAVE_CNT-1:0]      SLAVE_SPAN = {8'd3, 8'd3, 8'd3, 8'd2, 8'd2},
    localparam int                         IDX_W      = (SLAVE_CNT > 1) ? $clog2(SLAVE_CNT) : 1
) (
    input  logic [XLEN-1:0]  m_addr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = SLAVE_CNT - 1; i >= 0; i--) begin
            if ((m_addr & ~span_mask(SLAVE_SPAN[8*i +: 8])) == SLAVE_BASE[XLEN*i +: XLEN]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pbus_arb_conn.sv
// Single-master peripheral-bus connector: zero-latency request forwarding to the
// decoded slave, response return from the latched slave, decode-miss and timeout faults.
//   state   | meaning
//   IDLE    | waiting for m_req; hit forwards s_req, miss raises bus_fault
//   BUSY    | access outstanding on slave r_idx, timer running
//   ERR     | one-cycle faulted response after a decode miss
module pbus_arb_conn
    import pbus_arb_conn_pkg::*;
#(
    parameter int                          SLAVE_CNT   = 5,
    parameter logic [XLEN*SLAVE_CNT-1:0]   SLAVE_BASE  = {32'hf0000000, 32'hb0000000, 32'ha0000000,
                                                          32'h90000000, 32'h80000000},
    parameter logic [8*SLAVE_CNT-1:0]      SLAVE_SPAN  = {8'd3, 8'd3, 8'd3, 8'd2, 8'd2},
    parameter int                          TIMEOUT_CYC = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           m_req,
    input  logic [XLEN-1:0]                m_addr,
    input  logic                           m_w_rb,
    input  logic [ACC_W-1:0]               m_acc,
    input  logic [BUS_WIDTH-1:0]           m_wdata,
    output logic                           m_resp,
    output logic [BUS_WIDTH-1:0]           m_rdata,
    output logic                           m_fault,
    output logic [SLAVE_CNT-1:0]           s_req,
    output logic [XLEN-1:0]                s_addr,
    output logic                           s_w_rb,
    output logic [ACC_W-1:0]               s_acc,
    output logic [BUS_WIDTH-1:0]           s_wdata,
    input  logic [SLAVE_CNT-1:0]           s_resp,
    input  logic [BUS_WIDTH*SLAVE_CNT-1:0] s_rdata,
    input  logic [SLAVE_CNT-1:0]           s_fault,
    output logic                           bus_fault,
    output logic                           tmo,
    output logic                           busy
);

    localparam int IDX_W = (SLAVE_CNT > 1) ? $clog2(SLAVE_CNT) : 1;

    arb_state_e         r_state;
    arb_state_e         w_next;
    logic [TIMER_W-1:0] r_timer;
    logic [IDX_W-1:0]   r_idx;

    logic               w_hit;
    logic [IDX_W-1:0]   w_dec_idx;
    logic               w_issue;
    logic               w_miss;
    logic               w_sel_resp;
    logic               w_timeout;

    pbus_addr_dec #(
        .SLAVE_CNT  (SLAVE_CNT),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_SPAN (SLAVE_SPAN)
    ) u_dec (
        .m_addr (m_addr),
        .hit    (w_hit),
        .idx    (w_dec_idx)
    );

    // Same-cycle forwarding is gated by rst so outputs stay at zero throughout reset.
    assign w_issue    = (r_state == ST_IDLE) && m_req && w_hit && !rst;
    assign w_miss     = (r_state == ST_IDLE) && m_req && !w_hit && !rst;
    assign w_sel_resp = s_resp[r_idx];
    assign w_timeout  = (r_state == ST_BUSY) && !w_sel_resp &&
                        (r_timer == TIMER_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            r_timer <= ((r_state == ST_BUSY) && (w_next == ST_BUSY)) ? r_timer + TIMER_W'(1) : '0;
            if (w_issue) begin
                r_idx <= w_dec_idx;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_next = ST_BUSY;
                end else if (w_miss) begin
                    w_next = ST_ERR;
                end
            end
            ST_BUSY: begin
                if (w_sel_resp || w_timeout) begin
                    w_next = ST_IDLE;
                end
            end
            ST_ERR:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_req     = '0;
        s_addr    = '0;
        s_w_rb    = 1'b0;
        s_acc     = '0;
        s_wdata   = '0;
        bus_fault = w_miss;
        m_resp    = 1'b0;
        m_rdata   = '0;
        m_fault   = 1'b0;
        tmo       = 1'b0;
        busy      = 1'b0;
        if (w_issue) begin
            s_req[w_dec_idx] = 1'b1;
            s_addr  = m_addr & span_mask(SLAVE_SPAN[8*w_dec_idx +: 8]);
            s_w_rb  = m_w_rb;
            s_acc   = m_acc;
            s_wdata = m_wdata;
        end
        case (r_state)
            ST_BUSY: begin
                busy    = 1'b1;
                m_resp  = w_sel_resp || w_timeout;
                m_rdata = w_sel_resp ? s_rdata[BUS_WIDTH*r_idx +: BUS_WIDTH] : '0;
                m_fault = w_sel_resp ? s_fault[r_idx] : w_timeout;
                tmo     = w_timeout;
            end
            ST_ERR: begin
                m_resp  = 1'b1;
                m_fault = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pbus_arb_conn.sv
// Self-checking bench for pbus_arb_conn: directed vector table, hand sequences for
// reset and overlapping windows, and random transactions against a transaction model.
module tb_pbus_arb_conn;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut_a: default windows, short timeout
    logic         m_req = 0, m_w_rb = 0;
    logic [31:0]  m_addr = 0, m_wdata = 0;
    logic [1:0]   m_acc = 0;
    logic         m_resp, m_fault, s_w_rb, bus_fault, tmo, busy;
    logic [31:0]  m_rdata, s_addr, s_wdata;
    logic [1:0]   s_acc;
    logic [4:0]   s_req;
    logic [4:0]   s_resp = 0, s_fault = 0;
    logic [31:0]  lane_a [5];
    logic [159:0] s_rdata;
    assign s_rdata = {lane_a[4], lane_a[3], lane_a[2], lane_a[1], lane_a[0]};

    // dut_b: slave 2 window overlaps slave 0
    logic         m_req_b = 0;
    logic [31:0]  m_addr_b = 0;
    logic         m_resp_b, m_fault_b, s_w_rb_b, bus_fault_b, tmo_b, busy_b;
    logic [31:0]  m_rdata_b, s_addr_b, s_wdata_b;
    logic [1:0]   s_acc_b;
    logic [4:0]   s_req_b;
    logic [4:0]   s_resp_b = 0;
    logic [31:0]  lane_b [5];
    logic [159:0] s_rdata_b;
    assign s_rdata_b = {lane_b[4], lane_b[3], lane_b[2], lane_b[1], lane_b[0]};

    pbus_arb_conn #(.TIMEOUT_CYC(TMO)) dut_a (
        .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_w_rb(m_w_rb),
        .m_acc(m_acc), .m_wdata(m_wdata), .m_resp(m_resp), .m_rdata(m_rdata),
        .m_fault(m_fault), .s_req(s_req), .s_addr(s_addr), .s_w_rb(s_w_rb),
        .s_acc(s_acc), .s_wdata(s_wdata), .s_resp(s_resp), .s_rdata(s_rdata),
        .s_fault(s_fault), .bus_fault(bus_fault), .tmo(tmo), .busy(busy)
    );

    pbus_arb_conn #(
        .SLAVE_BASE({32'hf0000000, 32'hb0000000, 32'h80000000, 32'h90000000, 32'h80000000})
    ) dut_b (
        .clk(clk), .rst(rst), .m_req(m_req_b), .m_addr(m_addr_b), .m_w_rb(1'b0),
        .m_acc(2'd0), .m_wdata(32'd0), .m_resp(m_resp_b), .m_rdata(m_rdata_b),
        .m_fault(m_fault_b), .s_req(s_req_b), .s_addr(s_addr_b), .s_w_rb(s_w_rb_b),
        .s_acc(s_acc_b), .s_wdata(s_wdata_b), .s_resp(s_resp_b), .s_rdata(s_rdata_b),
        .s_fault(5'd0), .bus_fault(bus_fault_b), .tmo(tmo_b), .busy(busy_b)
    );

    int unsigned BASE [5] = '{32'h80000000, 32'h90000000, 32'ha0000000, 32'hb0000000, 32'hf0000000};
    int unsigned SPAN [5] = '{2, 2, 3, 3, 3};

    int n_chk = 0;
    int n_err = 0;

    // Lowest slave whose window (base with the low SPAN bits free) contains a, else -1.
    function automatic int model_dec(input logic [31:0] a);
        for (int i = 0; i < 5; i++) begin
            if ((a >> SPAN[i]) == (BASE[i] >> SPAN[i])) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [4:0] e_sreq, input logic e_bf,
                       input logic e_resp, input logic e_fault, input logic [31:0] e_rdata,
                       input logic e_tmo, input logic e_busy, input logic [31:0] e_saddr);
        logic [108:0] act, exp;
        logic [34:0]  wside;
        @(negedge clk);
        wside = (e_sreq != 5'd0) ? {m_w_rb, m_acc, m_wdata} : 35'd0;
        exp = {e_sreq, e_bf, e_resp, e_fault, e_rdata, e_tmo, e_busy, e_saddr, wside};
        act = {s_req, bus_fault, m_resp, m_fault, m_rdata, tmo, busy, s_addr, s_w_rb, s_acc, s_wdata};
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string nm, input logic [4:0] e_sreq, input logic e_resp,
                         input logic [31:0] e_rdata, input logic e_busy, input logic [31:0] e_saddr);
        logic [70:0] act, exp;
        @(negedge clk);
        exp = {e_sreq, e_resp, e_rdata, e_busy, e_saddr};
        act = {s_req_b, m_resp_b, m_rdata_b, busy_b, s_addr_b};
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        wrb;
        logic [4:0]  resp;
        logic [4:0]  flt;
        logic [7:0]  rd;
        logic [4:0]  e_sreq;
        logic        e_bf, e_resp, e_fault;
        logic [31:0] e_rdata;
        logic        e_tmo, e_busy;
        logic [31:0] e_saddr;
    } vec_t;

    vec_t tv [22];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idx, d, g, r, s;
        logic [31:0] a;
        logic [31:0] msk;

        tv[0]  = '{1, 32'h90000001, 0, 5'b00000, 5'b00000, 8'h00, 5'b00010, 0, 0, 0, 32'h0,        0, 0, 32'h1};
        tv[1]  = '{0, 32'h0,        0, 5'b00000, 5'b00000, 8'h00, 5'b00000, 0, 0, 0, 32'h0,        0, 1, 32'h0};
        tv[2]  = '{0, 32'h0,        0, 5'b00000, 5'b00000, 8'h00, 5'b00000, 0, 0, 0, 32'h0,        0, 1, 32'h0};
        tv[3]  = '{0, 32'h0,        0, 5'b00010, 5'b00000, 8'h5a, 5'b00000, 0, 1, 0, 32'h0001005a, 0, 1, 32'h0};
        tv[4]  = '{1, 32'h12345678, 1, 5'b00000, 5'b00000, 8'h00, 5'b00000, 1, 0, 0, 32'h0,        0, 0, 32'h0};
        tv[5]  = '{1, 32'h80000000, 0, 5'b00000, 5'b00000, 8'h00, 5'b00000, 0, 1, 1, 32'h0,        0, 0, 32'h0};
        tv[6]  = '{1, 32'hf0000005, 1, 5'b00000, 5'b00000, 8'h00, 5'b10000, 0, 0, 0, 32'h0,        0, 0, 32'h5};
        tv[7]  = '{0, 32'h0,        0, 5'b00000, 5'b00000, 8'h00, 5'b00000, 0, 0, 0, 32'h0,        0, 1, 32'h0};
        tv[8]  = '{0, 32'h0,        0, 5'b00000, 5'b00000, 8'h00, 5'b00000, 0, 0, 0, 32'h0,        0, 1, 32'h0};
        tv[9]  = '{1, 32'h80000000, 0, 5'b00001, 5'b00000, 8'h11, 5'b00000, 0, 0, 0, 32'h0,        0, 1, 32'h0};
        tv[10] = '{0, 32'h0,        0, 5'b00000, 5'b00000, 8'h00, 5'b00000, 0, 1, 1, 32'h0,        1, 1, 32'h0};
        tv[11] = '{0, 32'h0,        0, 5'b00000, 5'b00000, 8'h00, 5'b00000, 0, 0, 0, 32'h0,        0, 0, 32'h0};
        tv[12] = '{0, 32'h0,        0, 5'b10000, 5'b00000, 8'haa, 5'b00000, 0, 0, 0, 32'h0,        0, 0, 32'h0};
        tv[13] = '{1, 32'h80000002, 0, 5'b00000, 5'b00000, 8'h00, 5'b00001, 0, 0, 0, 32'h0,        0, 0, 32'h2};
        tv[14] = '{0, 32'h0,        0, 5'b00011, 5'b00001, 8'h33, 5'b00000, 0, 1, 1, 32'h00000033, 0, 1, 32'h0};
        tv[15] = '{1, 32'ha0000007, 1, 5'b00000, 5'b00000, 8'h00, 5'b00100, 0, 0, 0, 32'h0,        0, 0, 32'h7};
        tv[16] = '{0, 32'h0,        0, 5'b00000, 5'b00000, 8'h00, 5'b00000, 0, 0, 0, 32'h0,        0, 1, 32'h0};
        tv[17] = '{0, 32'h0,        0, 5'b00000, 5'b00000, 8'h00, 5'b00000, 0, 0, 0, 32'h0,        0, 1, 32'h0};
        tv[18] = '{0, 32'h0,        0, 5'b00000, 5'b00000, 8'h00, 5'b00000, 0, 0, 0, 32'h0,        0, 1, 32'h0};
        tv[19] = '{0, 32'h0,        0, 5'b00100, 5'b00000, 8'h77, 5'b00000, 0, 1, 0, 32'h00020077, 0, 1, 32'h0};
        tv[20] = '{1, 32'h90000004, 0, 5'b00000, 5'b00000, 8'h00, 5'b00000, 1, 0, 0, 32'h0,        0, 0, 32'h0};
        tv[21] = '{0, 32'h0,        0, 5'b00000, 5'b00000, 8'h00, 5'b00000, 0, 1, 1, 32'h0,        0, 0, 32'h0};

        for (int i = 0; i < 5; i++) begin
            lane_a[i] = 32'h0;
            lane_b[i] = 32'h0;
        end

        // Reset: outputs held at zero even with a valid request on the bus.
        m_req = 1; m_addr = 32'h80000000; m_wdata = 32'h12345678;
        chk("reset_outputs", 5'b0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        rst = 0;

        for (int k = 0; k < 22; k++) begin
            m_req = tv[k].req; m_addr = tv[k].addr; m_w_rb = tv[k].wrb;
            m_acc = 2'(k); m_wdata = 32'hc0de0000 + 32'(k);
            s_resp = tv[k].resp; s_fault = tv[k].flt;
            for (int i = 0; i < 5; i++) lane_a[i] = 32'(tv[k].rd) | (32'(i) << 16);
            chk($sformatf("vec%0d", k), tv[k].e_sreq, tv[k].e_bf, tv[k].e_resp, tv[k].e_fault,
                tv[k].e_rdata, tv[k].e_tmo, tv[k].e_busy, tv[k].e_saddr);
        end

        // Reset in the middle of an access drops it.
        m_req = 1; m_addr = 32'h90000000; m_w_rb = 0; s_resp = 0; s_fault = 0;
        chk("rst_mid_issue", 5'b00010, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        m_req = 0;
        chk("rst_mid_busy", 5'b0, 0, 0, 0, 32'h0, 0, 1, 32'h0);
        rst = 1; s_resp = 5'b00010; lane_a[1] = 32'h000000ee;
        #1;
        n_chk++;
        if ({busy, m_resp, m_fault, tmo, s_req, bus_fault, m_rdata} !== 41'd0) begin
            n_err++;
            $display("FAIL rst_async_zero: got %h want 0", {busy, m_resp, m_fault, tmo, s_req, bus_fault, m_rdata});
        end
        chk("rst_held", 5'b0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        rst = 0; s_resp = 0;
        chk("rst_no_late_resp", 5'b0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        m_req = 1; m_addr = 32'h90000002;
        chk("post_rst_issue", 5'b00010, 0, 0, 0, 32'h0, 0, 0, 32'h2);
        m_req = 0; s_resp = 5'b00010; lane_a[1] = 32'h00000042;
        chk("post_rst_resp", 5'b0, 0, 1, 0, 32'h42, 0, 1, 32'h0);
        s_resp = 0;

        // Overlapping windows on dut_b.
        m_req_b = 1; m_addr_b = 32'h80000001;
        chk_b("ovl_issue", 5'b00001, 0, 32'h0, 0, 32'h1);
        m_req_b = 0; s_resp_b = 5'b00100; lane_b[2] = 32'hff;
        chk_b("ovl_stray", 5'b0, 0, 32'h0, 1, 32'h0);
        s_resp_b = 5'b00001; lane_b[0] = 32'h12;
        chk_b("ovl_resp", 5'b0, 1, 32'h12, 1, 32'h0);
        m_req_b = 1; m_addr_b = 32'h80000005; s_resp_b = 0;
        chk_b("ovl_upper_issue", 5'b00100, 0, 32'h0, 0, 32'h5);
        m_req_b = 0; s_resp_b = 5'b00100; lane_b[2] = 32'h34;
        chk_b("ovl_upper_resp", 5'b0, 1, 32'h34, 1, 32'h0);
        s_resp_b = 0;
        chk_b("ovl_idle", 5'b0, 0, 32'h0, 0, 32'h0);

        // Random transactions against the transaction-level model.
        for (int t = 0; t < 250; t++) begin
            if ($urandom_range(0, 4) != 0) begin
                s = $urandom_range(0, 4);
                a = BASE[s] | ($urandom & ((32'd1 << SPAN[s]) - 32'd1));
            end else begin
                a = $urandom;
            end
            idx = model_dec(a);
            m_req = 1; m_addr = a; m_w_rb = 1'($urandom); m_acc = 2'($urandom); m_wdata = $urandom;
            s_resp = 5'($urandom); s_fault = 5'($urandom);
            for (int i = 0; i < 5; i++) lane_a[i] = $urandom;
            if (idx >= 0) begin
                msk = (32'd1 << SPAN[idx]) - 32'd1;
                chk("rnd_issue", 5'(1 << idx), 0, 0, 0, 32'h0, 0, 0, a & msk);
                d = $urandom_range(1, 6);
                r = (d < TMO) ? d : TMO;
                for (int k = 1; k <= r; k++) begin
                    m_req = ($urandom_range(0, 3) == 0); m_addr = $urandom;
                    s_resp = 5'($urandom) & ~5'(1 << idx);
                    if (k == d) s_resp = s_resp | 5'(1 << idx);
                    s_fault = 5'($urandom);
                    for (int i = 0; i < 5; i++) lane_a[i] = $urandom;
                    if (k < r)
                        chk("rnd_wait", 5'b0, 0, 0, 0, 32'h0, 0, 1, 32'h0);
                    else if (d <= TMO)
                        chk("rnd_resp", 5'b0, 0, 1, s_fault[idx], lane_a[idx], 0, 1, 32'h0);
                    else
                        chk("rnd_timeout", 5'b0, 0, 1, 1, 32'h0, 1, 1, 32'h0);
                end
            end else begin
                chk("rnd_miss", 5'b0, 1, 0, 0, 32'h0, 0, 0, 32'h0);
                m_req = 1'($urandom); m_addr = $urandom; s_resp = 5'($urandom);
                chk("rnd_err", 5'b0, 0, 1, 1, 32'h0, 0, 0, 32'h0);
            end
            g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) begin
                m_req = 0; s_resp = 5'($urandom); s_fault = 5'($urandom);
                for (int i = 0; i < 5; i++) lane_a[i] = $urandom;
                chk("rnd_idle", 5'b0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
